// File: rtl/buffer_ram_pkg.sv
// Shared types and width helpers for buffer_ram clients.
package buffer_ram_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } fill_state_t;

  // Address field sized for the default 240x240 frame.
  localparam int unsigned PIX_AW = 16;

  typedef struct packed {
    logic [PIX_AW-1:0] addr;
    logic [7:0]        r;
    logic [7:0]        g;
    logic [7:0]        b;
  } pixel_t;

  function automatic int unsigned coord_w(input int unsigned limit);
    return (limit > 1) ? $clog2(limit) : 1;
  endfunction

  function automatic int unsigned addr_w(input int unsigned x_limit, input int unsigned y_limit);
    return coord_w(x_limit) + coord_w(y_limit);
  endfunction

endpackage

// File: rtl/rect_walker.sv
// Rectangle cursor: raster-walks (x0,y0)..(x1,y1), producing linear addresses by accumulation.
module rect_walker
  import buffer_ram_pkg::*;
#(
  parameter int unsigned X_LIMIT = 240,
  parameter int unsigned XW      = 8,
  parameter int unsigned YW      = 8,
  parameter int unsigned AW      = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          step,
  input  logic [XW-1:0] x0,
  input  logic [XW-1:0] x1,
  input  logic [YW-1:0] y0,
  input  logic [YW-1:0] y1,
  output logic [AW-1:0] addr,
  output logic          last
);

  logic [XW-1:0] x_q, x_d, x0_q, x0_d, x1_q, x1_d;
  logic [YW-1:0] y_q, y_d, y1_q, y1_d;
  logic [AW-1:0] row_base_q, row_base_d;

  always_comb begin
    x_d        = x_q;
    y_d        = y_q;
    x0_d       = x0_q;
    x1_d       = x1_q;
    y1_d       = y1_q;
    row_base_d = row_base_q;
    if (load) begin
      x_d        = x0;
      y_d        = y0;
      x0_d       = x0;
      x1_d       = x1;
      y1_d       = y1;
      // The only multiply: once per command, never per pixel.
      row_base_d = AW'(AW'(y0) * AW'(X_LIMIT));
    end else if (step) begin
      if (x_q == x1_q) begin
        x_d        = x0_q;
        y_d        = y_q + YW'(1);
        row_base_d = row_base_q + AW'(X_LIMIT);
      end else begin
        x_d = x_q + XW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q        <= '0;
      y_q        <= '0;
      x0_q       <= '0;
      x1_q       <= '0;
      y1_q       <= '0;
      row_base_q <= '0;
    end else begin
      x_q        <= x_d;
      y_q        <= y_d;
      x0_q       <= x0_d;
      x1_q       <= x1_d;
      y1_q       <= y1_d;
      row_base_q <= row_base_d;
    end
  end

  assign addr = row_base_q + AW'(x_q);
  assign last = (x_q == x1_q) && (y_q == y1_q);

endmodule

// File: rtl/buffer_ram_write_scheduler.sv
// Owns the buffer_ram write port; round-robin shares it between host pixels and the fill engine.
module buffer_ram_write_scheduler
  import buffer_ram_pkg::*;
#(
  parameter int unsigned X_LIMIT = 240,
  parameter int unsigned Y_LIMIT = 240,
  localparam int unsigned XW = coord_w(X_LIMIT),
  localparam int unsigned YW = coord_w(Y_LIMIT),
  localparam int unsigned AW = addr_w(X_LIMIT, Y_LIMIT)
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic [XW-1:0] PIX_X,
  input  logic [YW-1:0] PIX_Y,
  input  logic [7:0]    PIX_R,
  input  logic [7:0]    PIX_G,
  input  logic [7:0]    PIX_B,
  input  logic          PIX_VALID,
  output logic          PIX_READY,
  input  logic [XW-1:0] FILL_X0,
  input  logic [XW-1:0] FILL_X1,
  input  logic [YW-1:0] FILL_Y0,
  input  logic [YW-1:0] FILL_Y1,
  input  logic [7:0]    FILL_R,
  input  logic [7:0]    FILL_G,
  input  logic [7:0]    FILL_B,
  input  logic          FILL_VALID,
  output logic          FILL_READY,
  input  logic          FILL_ABORT,
  output logic          FILL_BUSY,
  output logic          FILL_DONE,
  output logic          FILL_ERR,
  output logic [AW-1:0] WRITE_RAM_ADDRESS,
  output logic [7:0]    WRITE_RAM_COLOR_R,
  output logic [7:0]    WRITE_RAM_COLOR_G,
  output logic [7:0]    WRITE_RAM_COLOR_B,
  output logic          WRITE_RAM
);

  fill_state_t   state_q, state_d;
  logic          err_q, err_d;
  logic          last_fill_q, last_fill_d;
  logic [7:0]    fr_q, fr_d, fg_q, fg_d, fb_q, fb_d;
  pixel_t        pix_q, pix_d;
  logic          wr_q, wr_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          ferr_q, ferr_d;

  logic          load_c;
  logic          walk_last_c;
  logic [AW-1:0] walk_addr_c;
  logic          cmd_ok_c, host_in_c;
  logic [AW-1:0] host_addr_c;
  logic          req_fill_c, req_host_c, gnt_fill_c, gnt_host_c;

  rect_walker #(
    .X_LIMIT (X_LIMIT),
    .XW      (XW),
    .YW      (YW),
    .AW      (AW)
  ) u_walker (
    .clk   (CLK),
    .rst_n (RESET),
    .load  (load_c),
    .step  (gnt_fill_c),
    .x0    (FILL_X0),
    .x1    (FILL_X1),
    .y0    (FILL_Y0),
    .y1    (FILL_Y1),
    .addr  (walk_addr_c),
    .last  (walk_last_c)
  );

  assign cmd_ok_c = (FILL_X0 <= FILL_X1) && (FILL_Y0 <= FILL_Y1) &&
                    (32'(FILL_X1) < X_LIMIT) && (32'(FILL_Y1) < Y_LIMIT);
  assign host_in_c   = (32'(PIX_X) < X_LIMIT) && (32'(PIX_Y) < Y_LIMIT);
  assign host_addr_c = AW'(AW'(PIX_Y) * AW'(X_LIMIT)) + AW'(PIX_X);

  // Round-robin: on contention the side not granted last time wins.
  assign req_fill_c = (state_q == FILL);
  assign req_host_c = PIX_VALID;
  assign gnt_fill_c = req_fill_c && (!req_host_c || !last_fill_q);
  assign gnt_host_c = req_host_c && !gnt_fill_c;

  assign PIX_READY  = gnt_host_c;
  assign FILL_READY = (state_q == IDLE);

  always_comb begin
    state_d     = state_q;
    err_d       = err_q;
    last_fill_d = last_fill_q;
    fr_d        = fr_q;
    fg_d        = fg_q;
    fb_d        = fb_q;
    pix_d       = pix_q;
    wr_d        = 1'b0;
    load_c      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (FILL_VALID) begin
          fr_d = FILL_R;
          fg_d = FILL_G;
          fb_d = FILL_B;
          if (cmd_ok_c) begin
            load_c  = 1'b1;
            err_d   = 1'b0;
            state_d = FILL;
          end else begin
            err_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      FILL: begin
        if (FILL_ABORT)                     state_d = IDLE;
        else if (gnt_fill_c && walk_last_c) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (req_fill_c && req_host_c) last_fill_d = gnt_fill_c;

    if (gnt_fill_c) begin
      wr_d  = 1'b1;
      pix_d = '{addr: PIX_AW'(walk_addr_c), r: fr_q, g: fg_q, b: fb_q};
    end else if (gnt_host_c && host_in_c) begin
      wr_d  = 1'b1;
      pix_d = '{addr: PIX_AW'(host_addr_c), r: PIX_R, g: PIX_G, b: PIX_B};
    end

    busy_d = (state_d == FILL);
    done_d = (state_d == DONE);
    ferr_d = (state_d == DONE) && err_d;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= IDLE;
      err_q       <= 1'b0;
      last_fill_q <= 1'b0;
      fr_q        <= '0;
      fg_q        <= '0;
      fb_q        <= '0;
      pix_q       <= '0;
      wr_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      err_q       <= err_d;
      last_fill_q <= last_fill_d;
      fr_q        <= fr_d;
      fg_q        <= fg_d;
      fb_q        <= fb_d;
      pix_q       <= pix_d;
      wr_q        <= wr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ferr_q      <= ferr_d;
    end
  end

  if (AW < PIX_AW) begin : g_trim
    logic unused_addr_bits;
    assign unused_addr_bits = ^pix_q.addr[PIX_AW-1:AW];
  end

  assign WRITE_RAM         = wr_q;
  assign WRITE_RAM_ADDRESS = AW'(pix_q.addr);
  assign WRITE_RAM_COLOR_R = pix_q.r;
  assign WRITE_RAM_COLOR_G = pix_q.g;
  assign WRITE_RAM_COLOR_B = pix_q.b;
  assign FILL_BUSY         = busy_q;
  assign FILL_DONE         = done_q;
  assign FILL_ERR          = ferr_q;

endmodule

// File: tb/tb_buffer_ram_write_scheduler.sv
// Scoreboard bench: expected RAM writes queued by stimulus, popped by a write monitor.
module tb_buffer_ram_write_scheduler;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [7:0]  PIX_X = '0, PIX_Y = '0, PIX_R = '0, PIX_G = '0, PIX_B = '0;
  logic        PIX_VALID = 1'b0;
  logic        PIX_READY;
  logic [7:0]  FILL_X0 = '0, FILL_X1 = '0, FILL_Y0 = '0, FILL_Y1 = '0;
  logic [7:0]  FILL_R = '0, FILL_G = '0, FILL_B = '0;
  logic        FILL_VALID = 1'b0, FILL_ABORT = 1'b0;
  logic        FILL_READY, FILL_BUSY, FILL_DONE, FILL_ERR;
  logic [15:0] WRITE_RAM_ADDRESS;
  logic [7:0]  WRITE_RAM_COLOR_R, WRITE_RAM_COLOR_G, WRITE_RAM_COLOR_B;
  logic        WRITE_RAM;

  buffer_ram_write_scheduler #(.X_LIMIT(240), .Y_LIMIT(240)) dut (
    .CLK(CLK), .RESET(RESET),
    .PIX_X(PIX_X), .PIX_Y(PIX_Y), .PIX_R(PIX_R), .PIX_G(PIX_G), .PIX_B(PIX_B),
    .PIX_VALID(PIX_VALID), .PIX_READY(PIX_READY),
    .FILL_X0(FILL_X0), .FILL_X1(FILL_X1), .FILL_Y0(FILL_Y0), .FILL_Y1(FILL_Y1),
    .FILL_R(FILL_R), .FILL_G(FILL_G), .FILL_B(FILL_B),
    .FILL_VALID(FILL_VALID), .FILL_READY(FILL_READY), .FILL_ABORT(FILL_ABORT),
    .FILL_BUSY(FILL_BUSY), .FILL_DONE(FILL_DONE), .FILL_ERR(FILL_ERR),
    .WRITE_RAM_ADDRESS(WRITE_RAM_ADDRESS),
    .WRITE_RAM_COLOR_R(WRITE_RAM_COLOR_R), .WRITE_RAM_COLOR_G(WRITE_RAM_COLOR_G),
    .WRITE_RAM_COLOR_B(WRITE_RAM_COLOR_B), .WRITE_RAM(WRITE_RAM)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] rgb;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  n_tests = 0;
  int  n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic void push(input int addr, input int r, input int g, input int b);
    wr_t e;
    e.addr = 32'(addr);
    e.rgb  = {8'h00, 8'(r), 8'(g), 8'(b)};
    exp_q.push_back(e);
  endfunction

  // Write monitor: every strobe must match the head of the expected queue.
  always @(negedge CLK) begin
    if (RESET && WRITE_RAM === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %0d expected no write", WRITE_RAM_ADDRESS);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 32'(WRITE_RAM_ADDRESS), mon_e.addr);
        check("wr_rgb", {8'h00, WRITE_RAM_COLOR_R, WRITE_RAM_COLOR_G, WRITE_RAM_COLOR_B}, mon_e.rgb);
      end
    end
  end

  task automatic drive_fill(input int x0, input int x1, input int y0, input int y1,
                            input int r, input int g, input int b);
    FILL_X0 = 8'(x0); FILL_X1 = 8'(x1); FILL_Y0 = 8'(y0); FILL_Y1 = 8'(y1);
    FILL_R = 8'(r); FILL_G = 8'(g); FILL_B = 8'(b);
    FILL_VALID = 1'b1;
  endtask

  task automatic drive_pix(input int x, input int y, input int r, input int g, input int b);
    PIX_X = 8'(x); PIX_Y = 8'(y); PIX_R = 8'(r); PIX_G = 8'(g); PIX_B = 8'(b);
  endtask

  // Uncontested command: measures done cycle (relative to accept), busy cycles, err.
  task automatic run_fill(input string name, input int x0, input int x1, input int y0, input int y1,
                          input int r, input int g, input int b,
                          input int exp_done_k, input int exp_busy, input int exp_err);
    int busy_n = 0, done_n = 0, done_k = -1, err_at = 0;
    @(negedge CLK);
    check({name, "_fill_ready"}, 32'(FILL_READY), 1);
    drive_fill(x0, x1, y0, y1, r, g, b);
    for (int k = 1; k <= 20; k++) begin
      @(negedge CLK);
      FILL_VALID = 1'b0;
      if (FILL_BUSY) busy_n++;
      if (FILL_DONE) begin
        done_n++;
        if (done_k < 0) begin
          done_k = k;
          err_at = int'(FILL_ERR);
        end
      end
    end
    check({name, "_done_cycle"}, 32'(done_k), 32'(exp_done_k));
    check({name, "_done_pulses"}, 32'(done_n), 1);
    check({name, "_busy_cycles"}, 32'(busy_n), 32'(exp_busy));
    check({name, "_err"}, 32'(err_at), 32'(exp_err));
    check({name, "_writes_drained"}, 32'(exp_q.size()), 0);
  endtask

  initial begin
    int h_acc, busy_n, done_k, done_n;

    // Reset state
    #1;
    check("rst_write", 32'(WRITE_RAM), 0);
    check("rst_addr", 32'(WRITE_RAM_ADDRESS), 0);
    check("rst_busy", 32'(FILL_BUSY), 0);
    check("rst_done", 32'(FILL_DONE), 0);
    check("rst_err", 32'(FILL_ERR), 0);
    check("rst_fill_ready", 32'(FILL_READY), 1);
    check("rst_pix_ready", 32'(PIX_READY), 0);
    @(negedge CLK);
    RESET = 1'b1;

    // Host pixel write plus an out-of-range pixel that is accepted but dropped
    @(negedge CLK);
    drive_pix(3, 2, 8'h11, 8'h22, 8'h33);
    PIX_VALID = 1'b1;
    push(483, 8'h11, 8'h22, 8'h33);
    #1 check("host_ready", 32'(PIX_READY), 1);
    @(negedge CLK);
    drive_pix(240, 0, 8'h44, 8'h55, 8'h66);
    #1 check("host_oob_ready", 32'(PIX_READY), 1);
    @(negedge CLK);
    PIX_VALID = 1'b0;
    check("host_oob_no_write", 32'(WRITE_RAM), 0);
    repeat (3) @(negedge CLK);
    check("host_drained", 32'(exp_q.size()), 0);

    // 2x2 fill
    push(1210, 8'hFF, 0, 0); push(1211, 8'hFF, 0, 0);
    push(1450, 8'hFF, 0, 0); push(1451, 8'hFF, 0, 0);
    run_fill("fill2x2", 10, 11, 5, 6, 8'hFF, 0, 0, 5, 4, 0);

    // Invalid command (x0 > x1)
    run_fill("invalid", 5, 4, 0, 0, 1, 2, 3, 1, 0, 1);

    // Contention: host streams (i,100) while a 4x1 fill runs at (20..23,10)
    for (int i = 0; i < 5; i++) begin
      push(24000 + i, 8'h40 + i, 8'h50 + i, 8'h60 + i);
      if (i < 4) push(2420 + i, 8'h0A, 8'h0B, 8'h0C);
    end
    @(negedge CLK);
    drive_fill(20, 23, 10, 10, 8'h0A, 8'h0B, 8'h0C);
    drive_pix(0, 100, 8'h40, 8'h50, 8'h60);
    PIX_VALID = 1'b1;
    h_acc = 0; busy_n = 0; done_k = -1;
    for (int k = 0; k < 16; k++) begin
      #1 if (PIX_VALID && PIX_READY) h_acc++;
      @(negedge CLK);
      FILL_VALID = 1'b0;
      if (FILL_BUSY) busy_n++;
      if (FILL_DONE && done_k < 0) done_k = k + 1;
      if (h_acc >= 5) PIX_VALID = 1'b0;
      else drive_pix(h_acc, 100, 8'h40 + h_acc, 8'h50 + h_acc, 8'h60 + h_acc);
    end
    check("contend_host_accepts", 32'(h_acc), 5);
    check("contend_done_cycle", 32'(done_k), 8);
    check("contend_busy_cycles", 32'(busy_n), 7);
    check("contend_drained", 32'(exp_q.size()), 0);

    // Abort in the third FILL cycle of a 4x4 fill
    push(12000, 8'h21, 8'h22, 8'h23); push(12001, 8'h21, 8'h22, 8'h23);
    push(12002, 8'h21, 8'h22, 8'h23);
    @(negedge CLK);
    drive_fill(0, 3, 50, 53, 8'h21, 8'h22, 8'h23);
    done_n = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge CLK);
      FILL_VALID = 1'b0;
      FILL_ABORT = (k == 3);
      if (FILL_DONE) done_n++;
      if (k == 4) begin
        check("abort_busy_low", 32'(FILL_BUSY), 0);
        check("abort_idle", 32'(FILL_READY), 1);
      end
    end
    check("abort_no_done", 32'(done_n), 0);
    check("abort_drained", 32'(exp_q.size()), 0);
    push(1687, 8'h99, 8'h88, 8'h77);
    run_fill("after_abort", 7, 7, 7, 7, 8'h99, 8'h88, 8'h77, 2, 1, 0);

    // Reset asserted mid-fill
    push(14400, 8'h77, 8'h77, 8'h77); push(14401, 8'h77, 8'h77, 8'h77);
    @(negedge CLK);
    drive_fill(0, 3, 60, 63, 8'h77, 8'h77, 8'h77);
    @(negedge CLK);
    FILL_VALID = 1'b0;
    repeat (2) @(negedge CLK);
    #2 RESET = 1'b0;
    #1;
    check("midrst_write", 32'(WRITE_RAM), 0);
    check("midrst_addr", 32'(WRITE_RAM_ADDRESS), 0);
    check("midrst_rgb", {8'h00, WRITE_RAM_COLOR_R, WRITE_RAM_COLOR_G, WRITE_RAM_COLOR_B}, 0);
    check("midrst_busy", 32'(FILL_BUSY), 0);
    check("midrst_done", 32'(FILL_DONE), 0);
    @(negedge CLK);
    RESET = 1'b1;
    #1 check("midrst_fill_ready", 32'(FILL_READY), 1);
    done_n = 0; busy_n = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      if (FILL_DONE) done_n++;
      if (FILL_BUSY) busy_n++;
    end
    check("midrst_no_done", 32'(done_n), 0);
    check("midrst_no_busy", 32'(busy_n), 0);
    check("midrst_drained", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish within 200000 time units");
    $fatal(1, "timeout");
  end

endmodule
